// File: rtl/occamy_regbus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : occamy_regbus_arbiter
// Description : Round-robin arbiter sharing one regbus target among NumReq
//               masters. Optional watchdog via OCCAMY_REGBUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module occamy_regbus_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               slv_valid_i,
    input  logic [NumReq-1:0]               slv_write_i,
    input  logic [NumReq*AddrWidth-1:0]     slv_addr_i,
    input  logic [NumReq*DataWidth-1:0]     slv_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   slv_wstrb_i,
    output logic [NumReq-1:0]               slv_ready_o,
    output logic [DataWidth-1:0]            slv_rdata_o,
    output logic                            slv_error_o,
    output logic                            mst_valid_o,
    output logic                            mst_write_o,
    output logic [AddrWidth-1:0]            mst_addr_o,
    output logic [DataWidth-1:0]            mst_wdata_o,
    output logic [DataWidth/8-1:0]          mst_wstrb_o,
    input  logic                            mst_ready_i,
    input  logic [DataWidth-1:0]            mst_rdata_i,
    input  logic                            mst_error_i,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int unsigned c_IDX_W  = $clog2(NumReq);
    localparam int unsigned c_STRB_W = DataWidth / 8;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [c_IDX_W-1:0] ptr_q, ptr_d;
    logic [c_IDX_W-1:0] gnt_q, gnt_d;

    logic               w_found;
    logic [c_IDX_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_ptr_inc;
    logic               w_busy;
    logic               w_req_held;
    logic               w_done;
    logic               w_abort;
    logic               w_mst_valid;

    assign w_busy      = (state_q == c_BUSY);
    assign w_req_held  = slv_valid_i[gnt_q];
    assign w_done      = w_busy && w_req_held && mst_ready_i;
    assign w_mst_valid = w_busy && w_req_held && !w_abort;
    assign w_ptr_inc   = (gnt_q == c_IDX_W'(NumReq - 1)) ? '0 : gnt_q + 1'b1;

    // Circular search for the first valid requester at or after ptr_q.
    always_comb begin
        int unsigned v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            v_idx = 32'(ptr_q) + i;
            if (v_idx >= NumReq) begin
                v_idx = v_idx - NumReq;
            end
            if (!w_found && slv_valid_i[c_IDX_W'(v_idx)]) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(v_idx);
            end
        end
    end

`ifdef OCCAMY_REGBUS_ARB_TIMEOUT_EN
    localparam int unsigned c_CNT_W = $clog2(TimeoutCycles);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    assign w_abort = w_busy && w_req_held && !mst_ready_i &&
                     (cnt_q == c_CNT_W'(TimeoutCycles - 1));

    // Held at zero in IDLE, so every BUSY period starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == c_IDLE) begin
            cnt_d = '0;
        end else if (!mst_ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_abort = 1'b0;

    // Watchdog limit is inert without the counter.
    if (TimeoutCycles < 2) begin : g_timeout_inert
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_found) begin
                    state_d = c_BUSY;
                    gnt_d   = w_sel;
                end
            end
            c_BUSY: begin
                // Completion, abort and a dropped request all end the grant.
                if (!w_req_held || mst_ready_i || w_abort) begin
                    state_d = c_IDLE;
                    ptr_d   = w_ptr_inc;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        slv_ready_o = '0;
        slv_rdata_o = '0;
        slv_error_o = 1'b0;
        mst_valid_o = w_mst_valid;
        mst_write_o = 1'b0;
        mst_addr_o  = '0;
        mst_wdata_o = '0;
        mst_wstrb_o = '0;
        busy_o      = w_busy;
        timeout_o   = w_abort;
        if (w_mst_valid) begin
            mst_write_o = slv_write_i[gnt_q];
            mst_addr_o  = slv_addr_i[gnt_q*AddrWidth +: AddrWidth];
            mst_wdata_o = slv_wdata_i[gnt_q*DataWidth +: DataWidth];
            mst_wstrb_o = slv_wstrb_i[gnt_q*c_STRB_W +: c_STRB_W];
        end
        if (w_done) begin
            slv_ready_o[gnt_q] = 1'b1;
            slv_rdata_o        = mst_rdata_i;
            slv_error_o        = mst_error_i;
        end else if (w_abort) begin
            slv_ready_o[gnt_q] = 1'b1;
            slv_error_o        = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_occamy_regbus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_occamy_regbus_arbiter
// Description : Directed self-checking bench for occamy_regbus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occamy_regbus_arbiter;

    localparam int NR = 4;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     slv_valid;
    logic [NR-1:0]     slv_write;
    logic [NR*AW-1:0]  slv_addr;
    logic [NR*DW-1:0]  slv_wdata;
    logic [NR*SW-1:0]  slv_wstrb;
    logic [NR-1:0]     slv_ready;
    logic [DW-1:0]     slv_rdata;
    logic              slv_error;
    logic              mst_valid;
    logic              mst_write;
    logic [AW-1:0]     mst_addr;
    logic [DW-1:0]     mst_wdata;
    logic [SW-1:0]     mst_wstrb;
    logic              mst_ready;
    logic [DW-1:0]     mst_rdata;
    logic              mst_error;
    logic              busy;
    logic              timeout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    occamy_regbus_arbiter #(
        .NumReq        (NR),
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .TimeoutCycles (TO)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_valid_i (slv_valid),
        .slv_write_i (slv_write),
        .slv_addr_i  (slv_addr),
        .slv_wdata_i (slv_wdata),
        .slv_wstrb_i (slv_wstrb),
        .slv_ready_o (slv_ready),
        .slv_rdata_o (slv_rdata),
        .slv_error_o (slv_error),
        .mst_valid_o (mst_valid),
        .mst_write_o (mst_write),
        .mst_addr_o  (mst_addr),
        .mst_wdata_o (mst_wdata),
        .mst_wstrb_o (mst_wstrb),
        .mst_ready_i (mst_ready),
        .mst_rdata_i (mst_rdata),
        .mst_error_i (mst_error),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".mst_valid"}, 64'(mst_valid), 64'd0);
        chk({tag, ".mst_addr"},  64'(mst_addr),  64'd0);
        chk({tag, ".mst_wdata"}, 64'(mst_wdata), 64'd0);
        chk({tag, ".slv_ready"}, 64'(slv_ready), 64'd0);
        chk({tag, ".slv_rdata"}, 64'(slv_rdata), 64'd0);
        chk({tag, ".slv_error"}, 64'(slv_error), 64'd0);
        chk({tag, ".timeout"},   64'(timeout),   64'd0);
    endtask

    task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        slv_write[k]           = wr;
        slv_addr[k*AW +: AW]   = a;
        slv_wdata[k*DW +: DW]  = d;
        slv_wstrb[k*SW +: SW]  = s;
    endtask

    initial begin
        rst       = 1'b1;
        slv_valid = '0;
        slv_write = '0;
        slv_addr  = '0;
        slv_wdata = '0;
        slv_wstrb = '0;
        mst_ready = 1'b0;
        mst_rdata = '0;
        mst_error = 1'b0;
        tick;
        tick;
        chk_zero("reset");
        rst = 1'b0;
        tick;

        // Single read from requester 2.
        set_req(2, 1'b0, 48'h0000_0200_0010, 32'h0, 4'h0);
        slv_valid = 4'b0100;
        #1 chk("rd.idle_valid", 64'(mst_valid), 64'd0);
        tick;
        chk("rd.busy",      64'(busy),      64'd1);
        chk("rd.mst_valid", 64'(mst_valid), 64'd1);
        chk("rd.mst_addr",  64'(mst_addr),  64'h0000_0200_0010);
        chk("rd.mst_write", 64'(mst_write), 64'd0);
        chk("rd.pre_ready", 64'(slv_ready), 64'd0);
        mst_rdata = 32'hCAFEF00D;
        mst_ready = 1'b1;
        #1;
        chk("rd.slv_ready", 64'(slv_ready), 64'b0100);
        chk("rd.slv_rdata", 64'(slv_rdata), 64'hCAFEF00D);
        chk("rd.slv_error", 64'(slv_error), 64'd0);
        tick;
        slv_valid = '0;
        mst_ready = 1'b0;
        mst_rdata = '0;
        #1;
        chk("rd.after_busy",  64'(busy),      64'd0);
        chk("rd.after_ready", 64'(slv_ready), 64'd0);
        chk("rd.after_rdata", 64'(slv_rdata), 64'd0);

        // Reset in the third cycle of a stalled BUSY (pointer is now 3).
        set_req(2, 1'b0, 48'h2000, 32'h0, 4'h0);
        slv_valid = 4'b0100;
        tick;
        chk("mr.busy", 64'(busy), 64'd1);
        tick;
        tick;
        rst = 1'b1;
        #1 chk_zero("midrst");
        slv_valid = '0;
        tick;
        rst = 1'b0;

        // Routing: requester 1 write against a waiting requester 3.
        set_req(1, 1'b1, 48'h1000, 32'h12345678, 4'hF);
        set_req(3, 1'b0, 48'h3000, 32'h0, 4'h0);
        slv_valid = 4'b1010;
        tick;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rt.addr",  64'(mst_addr),     64'h1000);
            chk("rt.wdata", 64'(mst_wdata),    64'h12345678);
            chk("rt.wstrb", 64'(mst_wstrb),    64'hF);
            chk("rt.write", 64'(mst_write),    64'd1);
            chk("rt.r3_lo", 64'(slv_ready[3]), 64'd0);
            tick;
        end
        mst_ready = 1'b1;
        #1 chk("rt.ready1", 64'(slv_ready), 64'b0010);
        tick;
        slv_valid = 4'b1000;
        mst_ready = 1'b0;
        #1 chk("rt.idle", 64'(busy), 64'd0);
        tick;
        chk("rt.addr3",  64'(mst_addr),  64'h3000);
        chk("rt.write3", 64'(mst_write), 64'd0);
        mst_ready = 1'b1;
        #1 chk("rt.ready3", 64'(slv_ready), 64'b1000);
        tick;
        slv_valid = '0;
        mst_ready = 1'b0;

        // All requesting, target always ready: order 0,1,2,3,0,...
        for (int k = 0; k < NR; k++) begin
            set_req(k, 1'b0, 48'(k) << 8, 32'h0, 4'h0);
        end
        slv_valid = 4'hF;
        mst_ready = 1'b1;
        mst_rdata = 32'hA5A50000;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("all.idle_ready", 64'(slv_ready), 64'd0);
            chk("all.idle_busy",  64'(busy),      64'd0);
            tick;
            chk("all.ready", 64'(slv_ready), 64'd1 << (i % NR));
            chk("all.addr",  64'(mst_addr),  64'(i % NR) << 8);
            chk("all.rdata", 64'(slv_rdata), 64'hA5A50000);
            tick;
        end
        slv_valid = '0;
        mst_ready = 1'b0;
        mst_rdata = '0;
        tick;

        // Requester 0 drops valid mid-grant; pointer still advances to 1.
        set_req(0, 1'b0, 48'h0AAA, 32'h0, 4'h0);
        set_req(1, 1'b1, 48'h1000, 32'h12345678, 4'hF);
        slv_valid = 4'b0001;
        tick;
        chk("drop.valid_hi", 64'(mst_valid), 64'd1);
        slv_valid = '0;
        #1;
        chk("drop.valid_lo", 64'(mst_valid), 64'd0);
        chk("drop.no_ready", 64'(slv_ready), 64'd0);
        tick;
        chk("drop.idle", 64'(busy), 64'd0);
        slv_valid = 4'b0011;
        tick;
        chk("drop.ptr", 64'(mst_addr), 64'h1000);
        mst_ready = 1'b1;
        #1 chk("drop.ready1", 64'(slv_ready), 64'b0010);
        tick;
        slv_valid = '0;
        mst_ready = 1'b0;
        tick;

`ifdef OCCAMY_REGBUS_ARB_TIMEOUT_EN
        // Target never ready: abort on the 8th BUSY cycle.
        set_req(2, 1'b0, 48'h2000, 32'h0, 4'h0);
        slv_valid = 4'b0100;
        mst_rdata = 32'hDEADBEEF;
        tick;
        for (int c = 1; c < TO; c++) begin
            #1;
            chk("to.early_to",    64'(timeout),   64'd0);
            chk("to.early_ready", 64'(slv_ready), 64'd0);
            chk("to.early_busy",  64'(busy),      64'd1);
            tick;
        end
        #1;
        chk("to.ready",     64'(slv_ready), 64'b0100);
        chk("to.error",     64'(slv_error), 64'd1);
        chk("to.timeout",   64'(timeout),   64'd1);
        chk("to.rdata",     64'(slv_rdata), 64'd0);
        chk("to.mst_valid", 64'(mst_valid), 64'd0);
        tick;
        slv_valid = '0;
        #1;
        chk("to.idle",    64'(busy),    64'd0);
        chk("to.to_lo",   64'(timeout), 64'd0);
        // Ready in the 8th cycle wins over the watchdog.
        slv_valid = 4'b0100;
        tick;
        for (int c = 1; c < TO; c++) begin
            tick;
        end
        mst_ready = 1'b1;
        mst_rdata = 32'h600DF00D;
        #1;
        chk("tor.timeout", 64'(timeout),   64'd0);
        chk("tor.ready",   64'(slv_ready), 64'b0100);
        chk("tor.rdata",   64'(slv_rdata), 64'h600DF00D);
        chk("tor.error",   64'(slv_error), 64'd0);
        tick;
        slv_valid = '0;
        mst_ready = 1'b0;
        tick;
`else
        // No watchdog: a 5000-cycle stall keeps BUSY until ready arrives.
        begin
            logic stayed_busy;
            stayed_busy = 1'b1;
            set_req(2, 1'b0, 48'h2000, 32'h0, 4'h0);
            slv_valid = 4'b0100;
            tick;
            repeat (5000) begin
                if (busy !== 1'b1 || timeout !== 1'b0 || slv_ready !== '0) begin
                    stayed_busy = 1'b0;
                end
                tick;
            end
            chk("stall.busy", 64'(stayed_busy), 64'd1);
            mst_ready = 1'b1;
            mst_rdata = 32'h51A11ED0;
            #1;
            chk("stall.ready", 64'(slv_ready), 64'b0100);
            chk("stall.rdata", 64'(slv_rdata), 64'h51A11ED0);
            chk("stall.to",    64'(timeout),   64'd0);
            tick;
            slv_valid = '0;
            mst_ready = 1'b0;
            #1 chk("stall.idle", 64'(busy), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
